// File: rtl/mandel_view_ctrl.sv
// Viewport controller for the Mandelbrot viewer: samples pan/zoom buttons on each
// rising edge of slow_clk, updates a Q4.28 view and hands it to the renderer.
module mandel_view_ctrl #(
  parameter int                         COORD_W   = 32,
  parameter logic signed [COORD_W-1:0]  INIT_CX   = -134217728,
  parameter logic signed [COORD_W-1:0]  INIT_CY   = 0,
  parameter logic        [COORD_W-1:0]  INIT_STEP = 1258291,
  parameter logic        [COORD_W-1:0]  MIN_STEP  = 16,
  parameter logic        [COORD_W-1:0]  MAX_STEP  = 4194304,
  parameter int                         PAN_SHIFT = 4,
  parameter logic signed [COORD_W-1:0]  C_MIN     = -536870912,
  parameter logic signed [COORD_W-1:0]  C_MAX     = 536870912
) (
  input  logic               CLK,
  input  logic               RESET,
  input  logic               slow_clk,
  input  logic               btn_up,
  input  logic               btn_down,
  input  logic               btn_left,
  input  logic               btn_right,
  input  logic               btn_zoom_in,
  input  logic               btn_zoom_out,
  input  logic               render_busy,
  output logic               render_start,
  output logic [COORD_W-1:0] center_x,
  output logic [COORD_W-1:0] center_y,
  output logic [COORD_W-1:0] step
);

  // Pan arithmetic is carried with enough headroom that step << PAN_SHIFT plus a
  // full-range coordinate can never wrap before clamping.
  localparam int EXT_W = COORD_W + PAN_SHIFT + 1;

  localparam logic signed [EXT_W-1:0] C_MIN_X = {{(PAN_SHIFT+1){C_MIN[COORD_W-1]}}, C_MIN};
  localparam logic signed [EXT_W-1:0] C_MAX_X = {{(PAN_SHIFT+1){C_MAX[COORD_W-1]}}, C_MAX};

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_APPLY = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;

  logic [1:0] state;
  logic       slow_clk_d;
  logic       tick;

  logic btn_up_p0;
  logic btn_down_p0;
  logic btn_left_p0;
  logic btn_right_p0;
  logic btn_zoom_in_p0;
  logic btn_zoom_out_p0;

  logic signed [COORD_W-1:0] wcx;
  logic signed [COORD_W-1:0] wcy;
  logic        [COORD_W-1:0] wstep;

  logic signed [EXT_W-1:0]   delta;
  logic signed [COORD_W-1:0] next_cx;
  logic signed [COORD_W-1:0] next_cy;
  logic        [COORD_W-1:0] next_step;
  logic                      changed;

  function automatic logic signed [COORD_W-1:0] clamp_coord(
    input logic signed [EXT_W-1:0] v
  );
    if (v > C_MAX_X) begin
      return C_MAX;
    end else if (v < C_MIN_X) begin
      return C_MIN;
    end
    return v[COORD_W-1:0];
  endfunction

  function automatic logic signed [COORD_W-1:0] pan_coord(
    input logic signed [COORD_W-1:0] c,
    input logic                      plus,
    input logic                      minus,
    input logic signed [EXT_W-1:0]   d
  );
    logic signed [EXT_W-1:0] sum;
    sum = {{(PAN_SHIFT+1){c[COORD_W-1]}}, c};
    if (plus && !minus) begin
      sum = sum + d;
    end else if (minus && !plus) begin
      sum = sum - d;
    end
    return clamp_coord(sum);
  endfunction

  function automatic logic [COORD_W-1:0] zoom_step(
    input logic [COORD_W-1:0] s,
    input logic               zin,
    input logic               zout
  );
    logic [COORD_W:0]   doubled;
    logic [COORD_W-1:0] halved;
    doubled = {s, 1'b0};
    halved  = s >> 1;
    if (zin && !zout) begin
      return (halved < MIN_STEP) ? MIN_STEP : halved;
    end else if (zout && !zin) begin
      return (doubled > {1'b0, MAX_STEP}) ? MAX_STEP : doubled[COORD_W-1:0];
    end
    return s;
  endfunction

  assign tick  = slow_clk & ~slow_clk_d;
  assign delta = {{(PAN_SHIFT+1){1'b0}}, wstep} << PAN_SHIFT;

  // APPLY stage: next view from the latched buttons, pan uses the pre-zoom step
  always_comb begin
    next_cx   = pan_coord(wcx, btn_right_p0, btn_left_p0, delta);
    next_cy   = pan_coord(wcy, btn_up_p0, btn_down_p0, delta);
    next_step = zoom_step(wstep, btn_zoom_in_p0, btn_zoom_out_p0);
    changed   = (next_cx != wcx) || (next_cy != wcy) || (next_step != wstep);
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state           <= S_WAIT;
      slow_clk_d      <= 1'b1;
      render_start    <= 1'b0;
      btn_up_p0       <= 1'b0;
      btn_down_p0     <= 1'b0;
      btn_left_p0     <= 1'b0;
      btn_right_p0    <= 1'b0;
      btn_zoom_in_p0  <= 1'b0;
      btn_zoom_out_p0 <= 1'b0;
    end else begin
      slow_clk_d   <= slow_clk;
      render_start <= 1'b0;
      case (state)
        S_IDLE: begin
          if (tick) begin
            btn_up_p0       <= btn_up;
            btn_down_p0     <= btn_down;
            btn_left_p0     <= btn_left;
            btn_right_p0    <= btn_right;
            btn_zoom_in_p0  <= btn_zoom_in;
            btn_zoom_out_p0 <= btn_zoom_out;
            state           <= S_APPLY;
          end
        end
        S_APPLY: begin
          state <= changed ? S_WAIT : S_IDLE;
        end
        S_WAIT: begin
          if (!render_busy) begin
            render_start <= 1'b1;
            state        <= S_IDLE;
          end
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

  // View registers: working copy updates in APPLY, published copy only with render_start
  always_ff @(posedge CLK) begin
    if (RESET) begin
      wcx      <= INIT_CX;
      wcy      <= INIT_CY;
      wstep    <= INIT_STEP;
      center_x <= INIT_CX;
      center_y <= INIT_CY;
      step     <= INIT_STEP;
    end else begin
      if (state == S_APPLY) begin
        wcx   <= next_cx;
        wcy   <= next_cy;
        wstep <= next_step;
      end
      if (state == S_WAIT && !render_busy) begin
        center_x <= wcx;
        center_y <= wcy;
        step     <= wstep;
      end
    end
  end

endmodule
